// File: rtl/syst_pkg.sv
// rtl/syst_pkg.sv - shared state encoding and accumulator width helper for the systolic array
package syst_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DRAIN,
    ST_OUT
  } state_t;

  // Width that holds the sum of n full-scale width x width products without overflow
  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

endpackage

// File: rtl/syst_mac_pe.sv
// rtl/syst_mac_pe.sv - one output-stationary MAC cell with east/south operand pass-through
module syst_mac_pe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 18,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic [ACC_WIDTH-1:0] acc
);

  localparam int EXT = ACC_WIDTH - WIDTH;

  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] b_ext;

  // Extending to the full accumulator width makes the truncated product exact mod 2^ACC_WIDTH
  assign a_ext = {{EXT{SIGNED && a_in[WIDTH-1]}}, a_in};
  assign b_ext = {{EXT{SIGNED && b_in[WIDTH-1]}}, b_in};

  // Forward operands and accumulate once per array step; clr wipes the cell for the next job
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + a_ext * b_ext;
    end
  end

endmodule

// File: rtl/syst_array_nxn.sv
// rtl/syst_array_nxn.sv - NxN output-stationary systolic matrix multiplier with skewed feeds
module syst_array_nxn
  import syst_pkg::*;
#(
  parameter int N         = 3,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = acc_width(WIDTH, N),
  parameter int SIGNED    = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*WIDTH-1:0]     in_a,
  input  logic [N*WIDTH-1:0]     in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*ACC_WIDTH-1:0] out_row,
  output logic [$clog2(N):0]     out_idx,
  output logic                   out_last
);

  localparam int IDX_W = $clog2(N) + 1;
  localparam int CNT_W = $clog2(2 * N) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((N > 1) ? 2 * N - 3 : 0);

  state_t           state;
  logic [IDX_W-1:0] beat;
  logic [CNT_W-1:0] drain;
  logic             step;
  logic             clr;

  logic [WIDTH-1:0]     a_h [N][N];
  logic [WIDTH-1:0]     b_v [N][N];
  logic [ACC_WIDTH-1:0] acc [N][N];

  // The array only moves on accepted beats or during drain, so input gaps never inject bubbles
  assign step = ((state == ST_LOAD) && in_valid) || (state == ST_DRAIN);
  assign clr  = (state == ST_OUT) && out_ready && out_last;

  genvar i, j;
  generate
    for (i = 0; i < N; i++) begin : g_edge
      logic [WIDTH-1:0] feed_a;
      logic [WIDTH-1:0] feed_b;
      assign feed_a = (state == ST_LOAD) ? in_a[i*WIDTH +: WIDTH] : '0;
      assign feed_b = (state == ST_LOAD) ? in_b[i*WIDTH +: WIDTH] : '0;
      if (i == 0) begin : g_direct
        assign a_h[0][0] = feed_a;
        assign b_v[0][0] = feed_b;
      end else begin : g_skew
        logic [WIDTH-1:0] sr_a [i];
        logic [WIDTH-1:0] sr_b [i];
        // Row/column i is delayed by i steps so matching operands meet in the right cell
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            for (int t = 0; t < i; t++) begin
              sr_a[t] <= '0;
              sr_b[t] <= '0;
            end
          end else if (step) begin
            sr_a[0] <= feed_a;
            sr_b[0] <= feed_b;
            for (int t = 1; t < i; t++) begin
              sr_a[t] <= sr_a[t-1];
              sr_b[t] <= sr_b[t-1];
            end
          end
        end
        assign a_h[i][0] = sr_a[i-1];
        assign b_v[0][i] = sr_b[i-1];
      end
    end

    for (i = 0; i < N; i++) begin : g_row
      for (j = 0; j < N; j++) begin : g_col
        logic [WIDTH-1:0] a_o;
        logic [WIDTH-1:0] b_o;
        syst_mac_pe #(
          .WIDTH    (WIDTH),
          .ACC_WIDTH(ACC_WIDTH),
          .SIGNED   (SIGNED != 0)
        ) u_pe (
          .clk  (clk),
          .rstn (rstn),
          .en   (step),
          .clr  (clr),
          .a_in (a_h[i][j]),
          .b_in (b_v[i][j]),
          .a_out(a_o),
          .b_out(b_o),
          .acc  (acc[i][j])
        );
        if (j < N - 1) begin : g_east
          assign a_h[i][j+1] = a_o;
        end else begin : g_east_edge
          logic [WIDTH-1:0] a_east_unused;
          assign a_east_unused = a_o;
        end
        if (i < N - 1) begin : g_south
          assign b_v[i+1][j] = b_o;
        end else begin : g_south_edge
          logic [WIDTH-1:0] b_south_unused;
          assign b_south_unused = b_o;
        end
      end
    end
  endgenerate

  // Present the accumulator row addressed by the current output index
  always_comb begin
    out_row = '0;
    for (int r = 0; r < N; r++) begin
      if (out_idx == IDX_W'(r)) begin
        for (int c = 0; c < N; c++) begin
          out_row[c*ACC_WIDTH +: ACC_WIDTH] = acc[r][c];
        end
      end
    end
  end

  // Job sequencing LOAD -> DRAIN -> OUT -> LOAD with registered handshake outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_LOAD;
      beat      <= '0;
      drain     <= '0;
      out_idx   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            if (beat == LAST_IDX) begin
              beat     <= '0;
              in_ready <= 1'b0;
              if (N == 1) begin
                state     <= ST_OUT;
                out_valid <= 1'b1;
                out_last  <= 1'b1;
              end else begin
                state <= ST_DRAIN;
                drain <= '0;
              end
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain == DRAIN_LAST) begin
            state     <= ST_OUT;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end else begin
            drain <= drain + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= ST_LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              in_ready  <= 1'b1;
            end else begin
              out_idx  <= out_idx + 1'b1;
              out_last <= ((out_idx + 1'b1) == LAST_IDX);
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_syst_array_nxn.sv
// tb/tb_syst_array_nxn.sv - directed and randomized checks of the NxN systolic multiplier
module tb_syst_array_nxn;

  logic        clk;
  logic        rstn;
  logic        v;
  logic        rdy;
  logic [1:0]  sel;
  logic [31:0] a;
  logic [31:0] b;

  logic ir_3, ov_3, ol_3, ir_3s, ov_3s, ol_3s, ir_1, ov_1, ol_1, ir_4, ov_4, ol_4;
  logic [2:0]  oi_3, oi_3s, oi_4;
  logic [0:0]  oi_1;
  logic [53:0] or_3, or_3s;
  logic [15:0] or_1;
  logic [71:0] or_4;

  logic        ir_o, ov_o, ol_o;
  logic [2:0]  oi_o;
  logic [71:0] row_o;

  logic [7:0]  ma [4][4];
  logic [7:0]  mb [4][4];
  logic [71:0] cap_u [4];
  logic [71:0] cap_s [4];

  int checks = 0;
  int failures = 0;

  syst_array_nxn #(.N(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rstn(rstn), .in_valid(v && sel == 2'd0), .in_ready(ir_3),
    .in_a(a[23:0]), .in_b(b[23:0]), .out_valid(ov_3), .out_ready(rdy),
    .out_row(or_3), .out_idx(oi_3), .out_last(ol_3));

  syst_array_nxn #(.N(3), .WIDTH(8), .SIGNED(1)) u_dut3s (
    .clk(clk), .rstn(rstn), .in_valid(v && sel == 2'd0), .in_ready(ir_3s),
    .in_a(a[23:0]), .in_b(b[23:0]), .out_valid(ov_3s), .out_ready(rdy),
    .out_row(or_3s), .out_idx(oi_3s), .out_last(ol_3s));

  syst_array_nxn #(.N(1), .WIDTH(8)) u_dut1 (
    .clk(clk), .rstn(rstn), .in_valid(v && sel == 2'd1), .in_ready(ir_1),
    .in_a(a[7:0]), .in_b(b[7:0]), .out_valid(ov_1), .out_ready(rdy),
    .out_row(or_1), .out_idx(oi_1), .out_last(ol_1));

  syst_array_nxn #(.N(4), .WIDTH(8)) u_dut4 (
    .clk(clk), .rstn(rstn), .in_valid(v && sel == 2'd2), .in_ready(ir_4),
    .in_a(a), .in_b(b), .out_valid(ov_4), .out_ready(rdy),
    .out_row(or_4), .out_idx(oi_4), .out_last(ol_4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ir_o = ir_3; ov_o = ov_3; ol_o = ol_3; oi_o = oi_3; row_o = 72'(or_3);
    if (sel == 2'd1) begin
      ir_o = ir_1; ov_o = ov_1; ol_o = ol_1; oi_o = {2'b00, oi_1}; row_o = 72'(or_1);
    end else if (sel == 2'd2) begin
      ir_o = ir_4; ov_o = ov_4; ol_o = ol_4; oi_o = oi_4; row_o = or_4;
    end
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int val(input logic [7:0] x, input bit sgn);
    if (sgn) return int'($signed(x));
    return int'(x);
  endfunction

  function automatic logic [71:0] exp_row(input int r, input int n, input bit sgn);
    logic [71:0] res;
    int aw;
    int s;
    aw  = (n == 1) ? 16 : 18;
    res = '0;
    for (int j = 0; j < n; j++) begin
      s = 0;
      for (int k = 0; k < n; k++) s += val(ma[r][k], sgn) * val(mb[k][j], sgn);
      res = res | (72'(s & ((1 << aw) - 1)) << (j * aw));
    end
    return res;
  endfunction

  task automatic load_t1();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = 8'(3 * i + k + 1);
        mb[i][k] = (i == k) ? 8'd1 : 8'd0;
      end
  endtask

  task automatic load_fill(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        ma[i][k] = av;
        mb[i][k] = bv;
      end
  endtask

  task automatic check_t1(input string tg);
    check({tg, "_row0"}, cap_u[0], 72'({18'd3, 18'd2, 18'd1}));
    check({tg, "_row1"}, cap_u[1], 72'({18'd6, 18'd5, 18'd4}));
    check({tg, "_row2"}, cap_u[2], 72'({18'd9, 18'd8, 18'd7}));
    check({tg, "_row2_signed"}, cap_s[2], 72'({18'd9, 18'd8, 18'd7}));
  endtask

  // Entered and left at a falling edge; cycle 0 is the cycle the first beat is offered
  task automatic job(input int n, input logic [5:0] vpat, input int stall, input string tg);
    int cyc, k, last, lim;
    logic [71:0] eu, es;
    cyc = 0; k = 0; last = 0;
    while (k < n && cyc < 40) begin
      check({tg, "_load_ready"}, 72'(ir_o), 72'(1));
      v   = (cyc < 6) ? vpat[cyc] : 1'b1;
      rdy = 1'b1;
      if (v) begin
        a = '0; b = '0;
        for (int i = 0; i < n; i++) begin
          a[i*8 +: 8] = ma[i][k];
          b[i*8 +: 8] = mb[k][i];
        end
        last = cyc;
        k++;
      end else begin
        a = $urandom; b = $urandom;
      end
      @(negedge clk); cyc++;
    end
    lim = last + 4 * n + 4;
    while (!ov_o && cyc < lim) begin
      check({tg, "_drain_ready"}, 72'(ir_o), 72'(0));
      v = 1'b1; a = $urandom; b = $urandom; rdy = 1'b1;
      @(negedge clk); cyc++;
    end
    check({tg, "_first_valid_cycle"}, 72'(cyc), 72'(last + ((n == 1) ? 1 : 2 * n - 1)));
    for (int r = 0; r < n; r++) begin
      eu = exp_row(r, n, 1'b0);
      es = exp_row(r, n, 1'b1);
      for (int s = 0; s <= stall; s++) begin
        rdy = (s == stall); v = 1'b1; a = $urandom; b = $urandom;
        check({tg, "_out_valid"}, 72'(ov_o), 72'(1));
        check({tg, "_out_idx"}, 72'(oi_o), 72'(r));
        check({tg, "_out_last"}, 72'(ol_o), 72'(r == n - 1));
        check({tg, "_out_in_ready"}, 72'(ir_o), 72'(0));
        check({tg, "_row"}, row_o, eu);
        if (n == 3) begin
          check({tg, "_row_signed"}, 72'(or_3s), es);
          check({tg, "_ctl_signed"}, 72'({ov_3s, ol_3s, ir_3s, oi_3s}),
                72'({1'b1, r == 2, 1'b0, 3'(r)}));
        end
        if (rdy) begin
          cap_u[r] = row_o;
          cap_s[r] = 72'(or_3s);
        end
        @(negedge clk);
      end
    end
    v = 1'b0; rdy = 1'b0;
    check({tg, "_reload_ready"}, 72'(ir_o), 72'(1));
    check({tg, "_done_valid"}, 72'(ov_o), 72'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; v = 1'b0; rdy = 1'b0; sel = 2'd0; a = '0; b = '0;
    load_fill(8'd0, 8'd0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", 72'(ir_3), 72'(1));
    check("rst_out_valid", 72'(ov_3), 72'(0));
    check("rst_out_last", 72'(ol_3), 72'(0));
    check("rst_out_idx", 72'(oi_3), 72'(0));
    check("rst_out_row", 72'(or_3), 72'(0));
    check("rst_out_row_n4", or_4, 72'(0));
    rstn = 1'b1;
    @(negedge clk);

    load_t1();
    job(3, 6'b111111, 0, "t1");
    check_t1("t1");

    load_fill(8'hFF, 8'hFF);
    job(3, 6'b111111, 0, "t2");
    check("t2_c11_unsigned", 72'(cap_u[1][35:18]), 72'(195075));
    check("t2_c11_signed", 72'(cap_s[1][35:18]), 72'(3));

    load_fill(8'hFF, 8'd2);
    job(3, 6'b111111, 0, "t3");
    check("t3_c20_signed", 72'(cap_s[2][17:0]), 72'(18'h3FFFA));
    check("t3_c02_unsigned", 72'(cap_u[0][53:36]), 72'(1530));

    load_t1();
    job(3, 6'b101001, 3, "t4");
    check_t1("t4");

    load_fill(8'hFF, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      a = {8'hFF, 8'hFF, 8'hFF}; b = {8'hFF, 8'hFF, 8'hFF}; v = 1'b1;
      @(negedge clk);
    end
    v = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_drain_in_ready", 72'(ir_3), 72'(0));
    #2 rstn = 1'b0;
    #1;
    check("t5_async_out_valid", 72'(ov_3), 72'(0));
    check("t5_async_in_ready", 72'(ir_3), 72'(1));
    @(negedge clk);
    rstn = 1'b1;
    load_t1();
    job(3, 6'b111111, 0, "t5");
    check_t1("t5");

    sel = 2'd1;
    for (int t = 0; t < 100; t++) begin
      ma[0][0] = 8'($urandom);
      mb[0][0] = 8'($urandom);
      job(1, 6'b111111, 0, "t6_n1");
    end

    sel = 2'd2;
    for (int t = 0; t < 100; t++) begin
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 4; k++) begin
          ma[i][k] = 8'($urandom);
          mb[i][k] = 8'($urandom);
        end
      job(4, 6'b111111, 0, "t6_n4");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
